// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared definitions for the tic-tac-toe board redraw path.
//   - Screen, cell and grid geometry constants.
//   - Command field widths and background colour.
//   - Cell index type (0..8, index = row*3 + col) and scheduler state enum.
//   - cell_x0 / cell_y0: top-left corner of a cell, built from constant
//     pitches so that no runtime multiply or divide is synthesised.
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int unsigned SCR_W   = 320;
   localparam int unsigned SCR_H   = 240;
   localparam int unsigned CELL_W  = 104;
   localparam int unsigned CELL_H  = 77;
   localparam int unsigned GAP_X   = 4;
   localparam int unsigned GAP_Y   = 4;
   localparam int unsigned COLOR_W = 3;
   localparam int unsigned N_CELLS = 9;

   localparam int unsigned X_W = 9;
   localparam int unsigned Y_W = 8;

   localparam int unsigned PITCH_X = CELL_W + GAP_X;
   localparam int unsigned PITCH_Y = CELL_H + GAP_Y;

   localparam logic [COLOR_W-1:0] BG_COLOR = 3'b111;

   typedef logic [3:0] cell_idx_t;

   typedef enum logic [1:0] {
      S_BG,
      S_IDLE,
      S_CELL
   } state_t;

   // Column is idx mod 3; enumerated so only constant pitches appear.
   function automatic logic [X_W-1:0] cell_x0(input cell_idx_t idx);
      case (idx)
         4'd0, 4'd3, 4'd6: cell_x0 = '0;
         4'd1, 4'd4, 4'd7: cell_x0 = X_W'(PITCH_X);
         default:          cell_x0 = X_W'(2 * PITCH_X);
      endcase
   endfunction

   // Row is idx div 3.
   function automatic logic [Y_W-1:0] cell_y0(input cell_idx_t idx);
      case (idx)
         4'd0, 4'd1, 4'd2: cell_y0 = '0;
         4'd3, 4'd4, 4'd5: cell_y0 = Y_W'(PITCH_Y);
         default:          cell_y0 = Y_W'(2 * PITCH_Y);
      endcase
   endfunction

endpackage

// File: rtl/dirty_pick.sv
// -----------------------------------------------------------------------------
// dirty_pick
//   Purely combinational priority picker over the cell dirty vector.
//   Ports:
//     dirty  in   N_CELLS  one bit per cell, set when the cell needs a redraw
//     idx    out  4        lowest set index (0 when nothing is set)
//     any    out  1        at least one bit set
// -----------------------------------------------------------------------------
module dirty_pick
   import display_pkg::*;
(
   input  logic [N_CELLS-1:0] dirty,
   output cell_idx_t          idx,
   output logic               any
);

   // Scanning downwards lets the lowest set bit win the last assignment.
   always_comb begin
      idx = '0;
      any = |dirty;
      for (int unsigned i = N_CELLS; i > 0; i--) begin
         if (dirty[i-1]) begin
            idx = cell_idx_t'(i - 1);
         end
      end
   end

endmodule

// File: rtl/cell_redraw_scheduler.sv
// -----------------------------------------------------------------------------
// cell_redraw_scheduler
//   Sequences redraws of the 3x3 tic-tac-toe board: one full-screen clear,
//   then one rectangle-fill command per changed cell, handed to the
//   rectangle filler over a valid/ready handshake.
//
//   Ports:
//     clk           in   1               system clock
//     rst           in   1               asynchronous reset, active-low
//     cell_color    in   9*COLOR_W       cell i at [i*COLOR_W +: COLOR_W]
//     force_redraw  in   1               pulse: full clear + repaint
//     cursor_cell   in   4               (CURSOR_HIGHLIGHT_EN only) >8 = none
//     cmd_valid     out  1               command valid
//     cmd_ready     in   1               filler accepts command
//     cmd_x0/y0     out  9/8             rectangle top-left corner
//     cmd_w/h       out  9/8             rectangle size
//     cmd_color     out  COLOR_W         fill colour
//     busy          out  1               state is not S_IDLE
//     frame_done    out  1               pulse: board settled after cell work
//
//   Optional feature macro: CURSOR_HIGHLIGHT_EN
//     Adds cursor_cell; the cursor cell is drawn with inverted colour and a
//     cursor move dirties both the old and the new cell.
// -----------------------------------------------------------------------------
module cell_redraw_scheduler
   import display_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CELLS*COLOR_W-1:0] cell_color,
   input  logic                       force_redraw,
`ifdef CURSOR_HIGHLIGHT_EN
   input  logic [3:0]                 cursor_cell,
`endif
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [X_W-1:0]             cmd_x0,
   output logic [Y_W-1:0]             cmd_y0,
   output logic [X_W-1:0]             cmd_w,
   output logic [Y_W-1:0]             cmd_h,
   output logic [COLOR_W-1:0]         cmd_color,
   output logic                       busy,
   output logic                       frame_done
);

   state_t                            state_q,      state_d;
   logic [N_CELLS-1:0]                dirty_q,      dirty_d;
   logic [N_CELLS-1:0][COLOR_W-1:0]   shadow_q,     shadow_d;
   logic [X_W-1:0]                    cmd_x0_q,     cmd_x0_d;
   logic [Y_W-1:0]                    cmd_y0_q,     cmd_y0_d;
   logic [X_W-1:0]                    cmd_w_q,      cmd_w_d;
   logic [Y_W-1:0]                    cmd_h_q,      cmd_h_d;
   logic [COLOR_W-1:0]                cmd_color_q,  cmd_color_d;
   logic                              cmd_valid_q,  cmd_valid_d;
   logic                              frame_done_q, frame_done_d;
   logic                              force_pend_q, force_pend_d;
   logic                              cell_done_q,  cell_done_d;
   cell_idx_t                         cur_idx_q,    cur_idx_d;
`ifdef CURSOR_HIGHLIGHT_EN
   logic [3:0]                        cursor_q,     cursor_d;
`endif

   logic [N_CELLS-1:0][COLOR_W-1:0]   draw_color;
   logic [N_CELLS-1:0]                changed;
   logic [N_CELLS-1:0]                cursor_mark;
   logic [N_CELLS-1:0]                dirty_eff;
   cell_idx_t                         pick_idx;
   logic                              pick_any;
   logic                              handshake;

   // Colour each cell should show on screen, and whether it differs from
   // what was last drawn there.
   always_comb begin
      cursor_mark = '0;
      for (int unsigned i = 0; i < N_CELLS; i++) begin
         draw_color[i] = cell_color[i*COLOR_W +: COLOR_W];
`ifdef CURSOR_HIGHLIGHT_EN
         if (cursor_cell == 4'(i)) begin
            draw_color[i] = ~cell_color[i*COLOR_W +: COLOR_W];
         end
         if ((cursor_cell != cursor_q) &&
             ((cursor_cell == 4'(i)) || (cursor_q == 4'(i)))) begin
            cursor_mark[i] = 1'b1;
         end
`endif
         changed[i] = (draw_color[i] != shadow_q[i]);
      end
   end

   assign dirty_eff = dirty_q | changed;
   assign handshake = cmd_valid_q && cmd_ready;

   dirty_pick u_pick (
      .dirty (dirty_eff),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      state_d      = state_q;
      dirty_d      = dirty_q;
      shadow_d     = shadow_q;
      cmd_x0_d     = cmd_x0_q;
      cmd_y0_d     = cmd_y0_q;
      cmd_w_d      = cmd_w_q;
      cmd_h_d      = cmd_h_q;
      cmd_color_d  = cmd_color_q;
      cmd_valid_d  = cmd_valid_q;
      frame_done_d = 1'b0;
      force_pend_d = force_pend_q | force_redraw;
      cell_done_d  = cell_done_q;
      cur_idx_d    = cur_idx_q;
`ifdef CURSOR_HIGHLIGHT_EN
      cursor_d     = cursor_cell;
`endif

      case (state_q)
         S_BG: begin
            // Out of reset the command registers are zero; the clear
            // command is loaded on the first cycle.
            if (!cmd_valid_q) begin
               cmd_x0_d    = '0;
               cmd_y0_d    = '0;
               cmd_w_d     = X_W'(SCR_W);
               cmd_h_d     = Y_W'(SCR_H);
               cmd_color_d = BG_COLOR;
               cmd_valid_d = 1'b1;
            end else if (handshake) begin
               dirty_d = '1;
               if (force_pend_d) begin
                  // A redraw request that arrived during the clear repeats
                  // it; the clear command stays loaded and valid.
                  force_pend_d = 1'b0;
               end else begin
                  cmd_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end

         S_IDLE: begin
            if (force_pend_d) begin
               force_pend_d = 1'b0;
               cmd_x0_d     = '0;
               cmd_y0_d     = '0;
               cmd_w_d      = X_W'(SCR_W);
               cmd_h_d      = Y_W'(SCR_H);
               cmd_color_d  = BG_COLOR;
               cmd_valid_d  = 1'b1;
               state_d      = S_BG;
            end else begin
               dirty_d = dirty_eff;
               if (pick_any) begin
                  cmd_x0_d    = cell_x0(pick_idx);
                  cmd_y0_d    = cell_y0(pick_idx);
                  cmd_w_d     = X_W'(CELL_W);
                  cmd_h_d     = Y_W'(CELL_H);
                  cmd_color_d = draw_color[pick_idx];
                  cmd_valid_d = 1'b1;
                  cur_idx_d   = pick_idx;
                  state_d     = S_CELL;
               end else if (cell_done_q) begin
                  frame_done_d = 1'b1;
                  cell_done_d  = 1'b0;
               end
            end
         end

         S_CELL: begin
            if (handshake) begin
               // Shadow records what was actually drawn, so a colour that
               // moved on while stalled is picked up again in S_IDLE.
               shadow_d[cur_idx_q] = cmd_color_q;
               dirty_d[cur_idx_q]  = 1'b0;
               cell_done_d         = 1'b1;
               if (force_pend_d) begin
                  force_pend_d = 1'b0;
                  cmd_x0_d     = '0;
                  cmd_y0_d     = '0;
                  cmd_w_d      = X_W'(SCR_W);
                  cmd_h_d      = Y_W'(SCR_H);
                  cmd_color_d  = BG_COLOR;
                  state_d      = S_BG;
               end else begin
                  cmd_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_BG;
         end
      endcase

      dirty_d = dirty_d | cursor_mark;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_BG;
         dirty_q      <= '1;
         shadow_q     <= '0;
         cmd_x0_q     <= '0;
         cmd_y0_q     <= '0;
         cmd_w_q      <= '0;
         cmd_h_q      <= '0;
         cmd_color_q  <= '0;
         cmd_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         force_pend_q <= 1'b0;
         cell_done_q  <= 1'b0;
         cur_idx_q    <= '0;
`ifdef CURSOR_HIGHLIGHT_EN
         cursor_q     <= '1;
`endif
      end else begin
         state_q      <= state_d;
         dirty_q      <= dirty_d;
         shadow_q     <= shadow_d;
         cmd_x0_q     <= cmd_x0_d;
         cmd_y0_q     <= cmd_y0_d;
         cmd_w_q      <= cmd_w_d;
         cmd_h_q      <= cmd_h_d;
         cmd_color_q  <= cmd_color_d;
         cmd_valid_q  <= cmd_valid_d;
         frame_done_q <= frame_done_d;
         force_pend_q <= force_pend_d;
         cell_done_q  <= cell_done_d;
         cur_idx_q    <= cur_idx_d;
`ifdef CURSOR_HIGHLIGHT_EN
         cursor_q     <= cursor_d;
`endif
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_x0     = cmd_x0_q;
   assign cmd_y0     = cmd_y0_q;
   assign cmd_w      = cmd_w_q;
   assign cmd_h      = cmd_h_q;
   assign cmd_color  = cmd_color_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != S_IDLE);

endmodule
